// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for a single-port SRAM with a shared tristate data bus.
// One SRAM access per cycle, arbitrated round-robin between push and pop.
module sram_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              sram_wr_en,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data
);

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   mem_cnt_r;
    op_t               last_op_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic [ADDR_W:0]   count_r;
    logic              full_r;
    logic              empty_r;

    logic              wr_req_s;
    logic              rd_req_s;
    logic              grant_wr_s;
    logic              grant_rd_s;
    logic [ADDR_W:0]   mem_cnt_n_s;
    logic              out_valid_n_s;
    logic [ADDR_W:0]   count_n_s;

    // Request generation and single-port arbitration; grants are held off while in reset.
    always_comb begin
        wr_req_s   = in_valid & (mem_cnt_r != DEPTH_C);
        rd_req_s   = (mem_cnt_r != '0) & (~out_valid_r | out_ready);
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (!reset_n) begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end else if (wr_req_s && rd_req_s) begin
            grant_wr_s = (last_op_r == OP_READ);
            grant_rd_s = (last_op_r == OP_WRITE);
        end else begin
            grant_wr_s = wr_req_s;
            grant_rd_s = rd_req_s;
        end
    end

    // Next-state occupancy so count/full/empty can be registered with post-edge values.
    always_comb begin
        mem_cnt_n_s = mem_cnt_r;
        case ({grant_wr_s, grant_rd_s})
            2'b10:   mem_cnt_n_s = mem_cnt_r + ONE_C;
            2'b01:   mem_cnt_n_s = mem_cnt_r - ONE_C;
            default: mem_cnt_n_s = mem_cnt_r;
        endcase
        if (grant_rd_s) begin
            out_valid_n_s = 1'b1;
        end else if (out_ready) begin
            out_valid_n_s = 1'b0;
        end else begin
            out_valid_n_s = out_valid_r;
        end
        count_n_s = mem_cnt_n_s + {{ADDR_W{1'b0}}, out_valid_n_s};
    end

    // Pointer, output slot and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            mem_cnt_r   <= '0;
            last_op_r   <= OP_READ;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
        end else begin
            if (grant_wr_s) begin
                wr_ptr_r  <= wr_ptr_r + ADDR_W'(1);
                last_op_r <= OP_WRITE;
            end else if (grant_rd_s) begin
                rd_ptr_r   <= rd_ptr_r + ADDR_W'(1);
                out_data_r <= sram_data;
                last_op_r  <= OP_READ;
            end else begin
                last_op_r <= last_op_r;
            end
            mem_cnt_r   <= mem_cnt_n_s;
            out_valid_r <= out_valid_n_s;
            count_r     <= count_n_s;
            full_r      <= (mem_cnt_n_s == DEPTH_C);
            empty_r     <= (count_n_s == '0);
        end
    end

    assign sram_wr_en = grant_wr_s;
    assign sram_rd_en = grant_rd_s;
    assign sram_addr  = grant_wr_s ? wr_ptr_r : rd_ptr_r;
    assign sram_data  = grant_wr_s ? in_data : {DATA_W{1'bz}};
    assign in_ready   = grant_wr_s;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign count      = count_r;
    assign full       = full_r;
    assign empty      = empty_r;

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed + random bench for sram_fifo_ctrl with an SRAM model on the shared bus
// and a queue scoreboard of accepted bytes.
module tb_sram_fifo_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] count;
    logic        full;
    logic        empty;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [9:0]  sram_addr;
    wire  [7:0]  sram_data;

    logic [7:0]  mem [1024];
    logic [7:0]  q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          pops = 0;
    bit          accepted;
    logic [7:0]  last_pop;

    sram_fifo_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .full(full), .empty(empty),
        .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
        .sram_data(sram_data)
    );

    always #5 clk = ~clk;

    // SRAM: combinational read onto the bus, write latched on the rising edge.
    assign sram_data = sram_rd_en ? mem[sram_addr] : 8'hzz;
    always @(posedge clk) begin
        if (sram_wr_en) mem[sram_addr] <= sram_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples the cycle at the falling edge, then advances past the next rising edge.
    task automatic tick();
        @(negedge clk);
        check("no_contention", 32'(sram_wr_en & sram_rd_en), 32'd0);
        if (sram_rd_en) check("bus_read", 32'(sram_data), 32'(mem[sram_addr]));
        accepted = in_ready;
        if (in_ready) q.push_back(in_data);
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL pop_empty observed=%0h expected=queued", out_data);
            end
            if (q.size() != 0) check("pop_data", 32'(out_data), 32'(q.pop_front()));
            last_pop = out_data;
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (accepted) break;
        end
        if (!accepted) check("send_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(q.size()), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        int start_cyc;
        int pops_before;

        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_wr_en", 32'(sram_wr_en), 32'd0);
        check("rst_rd_en", 32'(sram_rd_en), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Three bytes with a read-latency probe on the first.
        out_ready = 1'b1;
        send(8'h11);
        in_valid = 1'b0;
        check("lat_after_write", 32'(out_valid), 32'd0);
        tick();
        check("lat_after_read", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h11);
        send(8'h22);
        send(8'h33);
        in_valid = 1'b0;
        wait_drained(20);
        check("seq_pops", 32'(pops), 32'd3);
        check("seq_last", 32'(last_pop), 32'h33);

        // Fill with consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 1024; i++) send(8'(i));
        check("fill_count_1024", 32'(count), 32'd1024);
        check("fill_full_1024", 32'(full), 32'd0);
        send(8'h00);
        check("fill_count_1025", 32'(count), 32'd1025);
        check("fill_full", 32'(full), 32'd1);
        check("fill_slot", 32'(out_data), 32'h00);
        in_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            check("full_in_ready", 32'(in_ready), 32'd0);
            tick();
        end

        // Release consumer from full.
        out_ready = 1'b1;
        check("full_read_first", 32'(in_ready), 32'd0);
        tick();
        check("in_ready_return", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        wait_drained(3000);

        // Continuous stream: alternating W/R gives 2 cycles per byte after the first.
        start_cyc = cyc;
        for (int i = 0; i < 3000; i++) send(8'(i));
        check("stream_cycles", 32'(cyc - start_cyc), 32'd5999);
        in_valid = 1'b0;
        wait_drained(20);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drained(3000);

        // Reset in the middle of a stream.
        out_ready = 1'b0;
        for (int i = 0; i < 37; i++) send(8'(i + 100));
        check("pre_rst_count", 32'(count), 32'd37);
        in_data  = 8'h77;
        reset_n  = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_wr_en", 32'(sram_wr_en), 32'd0);
        q.delete();
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        pops_before = pops;
        send(8'hA5);
        in_valid = 1'b0;
        wait_drained(20);
        check("post_rst_pops", 32'(pops - pops_before), 32'd1);
        check("post_rst_data", 32'(last_pop), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
